// File: rtl/n101_ctrl_reg_wr_port.sv
// n101_ctrl_reg_wr_port
// ICB slave front-end for a bank of NREG control-register vectors, each WIDTH
// bits wide. A legal write produces one registered write-enable pulse plus data
// on reg_en/reg_d. A legal read returns the zero-extended reg_q slice. Every
// command receives exactly one ICB response, and illegal accesses set rsp_err.
//
// Ports:
//   clock, reset            : single clock, synchronous active-high reset
//   i_icb_cmd_*             : ICB command channel (valid/ready/addr/read/wdata)
//   i_icb_rsp_*             : ICB response channel (valid/ready/rdata/err)
//   reg_en [NREG]           : one-hot write enable, one bit per register vector
//   reg_d  [WIDTH]          : write data shared by all vectors
//   reg_q  [NREG*WIDTH]     : vector k's output sits at [k*WIDTH +: WIDTH]
//
// Optional feature: define N101_CTRL_REG_WLOCK_EN to add a sticky write lock.
// The lock is set by writing 1 to byte address 4*NREG, and it can be read back
// at that same address. While the lock is set, register writes are refused
// with rsp_err = 1.
module n101_ctrl_reg_wr_port #(
  parameter int NREG   = 4,
  parameter int WIDTH  = 5,
  parameter int ADDR_W = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_icb_cmd_valid,
  output logic                    i_icb_cmd_ready,
  input  logic [ADDR_W-1:0]       i_icb_cmd_addr,
  input  logic                    i_icb_cmd_read,
  input  logic [31:0]             i_icb_cmd_wdata,
  output logic                    i_icb_rsp_valid,
  input  logic                    i_icb_rsp_ready,
  output logic [31:0]             i_icb_rsp_rdata,
  output logic                    i_icb_rsp_err,
  output logic [NREG-1:0]         reg_en,
  output logic [WIDTH-1:0]        reg_d,
  input  logic [NREG*WIDTH-1:0]   reg_q
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   reg_en_q, reg_en_d;
  logic [WIDTH-1:0]  reg_d_q, reg_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic [ADDR_W-3:0] idx_s;
  logic [31:0]       idx_ext_s;
  logic              aligned_s;
  logic              legal_s;
  logic [NREG-1:0]   idx_onehot_s;
  logic [WIDTH-1:0]  rd_slice_s;
  logic              unused_wdata_s;

`ifdef N101_CTRL_REG_WLOCK_EN
  logic              lock_q, lock_d;
  logic              is_lock_s;
`endif

  // Zero-extend a register-vector value onto the 32-bit read bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign accept_s   = i_icb_cmd_valid & (state_q == ST_IDLE);
  assign idx_s      = i_icb_cmd_addr[ADDR_W-1:2];
  assign idx_ext_s  = 32'(idx_s);
  assign aligned_s  = (i_icb_cmd_addr[1:0] == 2'b00);
  assign legal_s    = aligned_s & (idx_ext_s < 32'(NREG));
  // Only the low WIDTH bits (and bit 0 for the lock) are meaningful.
  assign unused_wdata_s = ^i_icb_cmd_wdata;

`ifdef N101_CTRL_REG_WLOCK_EN
  assign is_lock_s  = aligned_s & (idx_ext_s == 32'(NREG));
`endif

  // Decode the index to one-hot and select the matching reg_q slice with an AND-OR mux.
  always_comb begin
    idx_onehot_s = '0;
    rd_slice_s   = '0;
    for (int k = 0; k < NREG; k++) begin
      idx_onehot_s[k] = (idx_ext_s == 32'(k));
      rd_slice_s      = rd_slice_s | (reg_q[k*WIDTH +: WIDTH] & {WIDTH{idx_onehot_s[k]}});
    end
  end

  // Next-state and next-output logic for the IDLE/RSP handshake FSM.
  always_comb begin
    state_d  = state_q;
    reg_en_d = '0;          // the enable lasts one cycle because it defaults low
    reg_d_d  = reg_d_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef N101_CTRL_REG_WLOCK_EN
    lock_d   = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RSP;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          if (legal_s) begin
            if (i_icb_cmd_read) begin
              err_d   = 1'b0;
              rdata_d = zext(rd_slice_s);
            end else begin
`ifdef N101_CTRL_REG_WLOCK_EN
              if (lock_q) begin
                err_d = 1'b1;
              end else begin
                err_d    = 1'b0;
                reg_en_d = idx_onehot_s;
                reg_d_d  = i_icb_cmd_wdata[WIDTH-1:0];
              end
`else
              err_d    = 1'b0;
              reg_en_d = idx_onehot_s;
              reg_d_d  = i_icb_cmd_wdata[WIDTH-1:0];
`endif
            end
          end else begin
`ifdef N101_CTRL_REG_WLOCK_EN
            if (is_lock_s) begin
              err_d = 1'b0;
              if (i_icb_cmd_read) begin
                rdata_d = {31'b0, lock_q};
              end else begin
                lock_d = lock_q | i_icb_cmd_wdata[0];
              end
            end else begin
              err_d = 1'b1;
            end
`else
            err_d = 1'b1;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (i_icb_rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reg_en_q <= '0;
      reg_d_q  <= '0;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
`ifdef N101_CTRL_REG_WLOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef N101_CTRL_REG_WLOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign i_icb_cmd_ready = (state_q == ST_IDLE);
  assign i_icb_rsp_valid = (state_q == ST_RSP);
  assign i_icb_rsp_rdata = rdata_q;
  assign i_icb_rsp_err   = err_q;
  assign reg_en          = reg_en_q;
  assign reg_d           = reg_d_q;

endmodule

// File: doc/n101_ctrl_reg_wr_port.md
# n101_ctrl_reg_wr_port

ICB slave front-end that owns a small bank of `NREG` control-register vectors, each `WIDTH` bits wide, inside a peripheral. It accepts ICB read and write commands. For a write, it drives one registered write-enable pulse and the data onto the `d`/`en` pins of the matching register-vector instance. For a read, it returns that instance's `q` value. Each command gets exactly one ICB response, with an error flag for illegal accesses. The block sits between the peripheral's ICB bus and its register-vector instances.

## Interface

Parameters:
- `NREG`, default 4: number of register vectors, 1..8.
- `WIDTH`, default 5: width of each register vector, 1..32.
- `ADDR_W`, default 5: ICB address bits decoded; `4*(NREG+1)` must be ≤ `2**ADDR_W`.

Ports:
- `clock`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `i_icb_cmd_valid`, input, 1: command valid.
- `i_icb_cmd_ready`, output, 1: command ready.
- `i_icb_cmd_addr`, input, `ADDR_W`: byte address.
- `i_icb_cmd_read`, input, 1: 1 = read, 0 = write.
- `i_icb_cmd_wdata`, input, 32: write data.
- `i_icb_rsp_valid`, output, 1: response valid.
- `i_icb_rsp_ready`, input, 1: response ready.
- `i_icb_rsp_rdata`, output, 32: read data, zero-extended.
- `i_icb_rsp_err`, output, 1: error response.
- `reg_en`, output, `NREG`: one-hot write enable, one bit per register vector.
- `reg_d`, output, `WIDTH`: write data, shared by all vectors.
- `reg_q`, input, `NREG*WIDTH`: concatenated vector outputs; vector k occupies `[k*WIDTH +: WIDTH]`.

## Operation

- Two-state FSM: IDLE and RSP.
- `i_icb_cmd_ready` = 1 only in IDLE.
- IDLE → RSP when `i_icb_cmd_valid & i_icb_cmd_ready` (accept).
- RSP → IDLE when `i_icb_rsp_valid & i_icb_rsp_ready`.
- `i_icb_rsp_valid` = 1 exactly while in RSP.
- Address decode at accept:
  - `idx = addr[ADDR_W-1:2]`.
  - A command is legal when `addr[1:0] == 0` and `idx < NREG`.
  - Any other address is illegal, except the lock address under the Configuration macro.
- Legal write:
  - The next cycle has `reg_en[idx] = 1` with all other `reg_en` bits 0.
  - `reg_d = wdata[WIDTH-1:0]`; upper wdata bits are ignored.
  - `rsp_err = 0`, `rsp_rdata = 0`.
- Legal read:
  - `rsp_rdata` = zero-extended `reg_q` slice for `idx`, sampled in the accept cycle.
  - `rsp_err = 0`.
- Illegal command:
  - `reg_en` stays all-zero.
  - `rsp_err = 1`, `rsp_rdata = 0`.
- Response outputs (`rsp_rdata`, `rsp_err`) are registered at accept and held stable while RSP waits for `i_icb_rsp_ready`.
- `reg_en` is always a single-cycle pulse and never repeats while RSP stalls.
- `reg_d` holds its last written value between writes.

## Timing

- Reset values: FSM = IDLE, `i_icb_cmd_ready = 1`, `i_icb_rsp_valid = 0`, `i_icb_rsp_rdata = 0`, `i_icb_rsp_err = 0`, `reg_en = 0`, `reg_d = 0`.
- Reset mid-transaction: any pending response is dropped, and no `reg_en` pulse appears after the reset edge.
- Write accepted at cycle N:
  - `reg_en`/`reg_d` are valid during cycle N+1.
  - The register vector's `q` reflects the new value from cycle N+2.
  - `i_icb_rsp_valid` rises at N+1.
- With `i_icb_rsp_ready` held at 1, the next command is accepted no earlier than N+2. Throughput is one command per 2 cycles.
- Read-after-write to the same index therefore always returns the new value; no bypass is needed.
- `i_icb_rsp_ready` low: the block stays in RSP indefinitely and `i_icb_cmd_ready` stays 0.
- `i_icb_cmd_valid` may drop while `i_icb_cmd_ready` = 0 without effect.

## Configuration

- Macro: `N101_CTRL_REG_WLOCK_EN`.
- Defined:
  - Adds a sticky `lock` flop, reset value 0.
  - Lock address is `4*NREG`.
  - Writing wdata[0] = 1 to the lock address sets `lock`; writing 0 has no effect; `lock` clears only on `reset`.
  - Reading the lock address returns `{31'b0, lock}` with `err = 0`.
  - While `lock` = 1, writes to any idx < NREG produce no `reg_en` pulse and return `err = 1`. Reads are unaffected.
- Undefined:
  - No `lock` flop exists.
  - Address `4*NREG` is illegal and returns `err = 1`.

## Test plan

- Reset, then write addr 0x4, wdata 0xFFFF_FFF3 with rsp_ready = 1:
  - `reg_en` = 4'b0010 for exactly 1 cycle, with `reg_d` = 5'h13.
  - rsp: err = 0, rdata = 0.
- Read addr 0x4 immediately after that write:
  - rdata = 0x13.
  - Total latency from write accept to read accept is 2 cycles.
- Write addr 0x6 (unaligned), and separately write addr 0x1C (out of range):
  - No `reg_en` pulse.
  - err = 1, rdata = 0.
- Hold rsp_ready = 0 for 5 cycles after a write:
  - `reg_en` pulses once.
  - rsp_valid/rdata/err stay stable.
  - cmd_ready stays 0 until the handshake.
- Assert `reset` in the cycle after accept, with rsp pending:
  - rsp_valid = 0 and `reg_en` = 0 after the edge.
  - cmd_ready = 1.
- `N101_CTRL_REG_WLOCK_EN`:
  - Write 1 to 0x10; a read of 0x10 returns 1.
  - A write to 0x0 then gives err = 1 with no `reg_en`.
  - After reset, the same write succeeds.
